game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Top-level game sequencer for the typing game. Owns the SELECT/COUNTDOWN/INGAME/FINISH state register.
- Drives `state`, `mode`, `value` and `random_id` into the typing/scoring datapath, and consumes that datapath's `finish` flag.
- Handles mode and target selection from one-pulse button/key strobes.
- Runs the 3-2-1 pre-game countdown and free-runs an LFSR that supplies dictionary word ids.

Parameters:
- CYC_PER_SEC, 100_000_000, clk cycles per countdown second.
- COUNT_SEC, 3, countdown start value in seconds (1..3).
- WORD_CNT, 100, number of dictionary entries; `random_id` range is 0..WORD_CNT-1.
- LFSR_SEED, 10'h2A5, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_p  in  1  one-cycle pulse: start game / leave result screen
- abort_p  in  1  one-cycle pulse: return to SELECT from COUNTDOWN or INGAME
- mode_p  in  1  one-cycle pulse: toggle mode (SELECT only)
- up_p  in  1  one-cycle pulse: increment value (SELECT only)
- down_p  in  1  one-cycle pulse: decrement value (SELECT only)
- finish  in  1  game-over flag from the scoring datapath
- state  out  2  0=SELECT, 1=COUNTDOWN, 2=INGAME, 3=FINISH
- mode  out  1  0=timed (value in seconds), 1=word count (value in words)
- value  out  7  selected target
- countdown  out  2  remaining countdown seconds; 0 outside COUNTDOWN
- random_id  out  10  registered word id, 0..WORD_CNT-1, new value every cycle

Behaviour:
- All registers update on posedge clk. rst is synchronous and overrides everything.
- Reset values: state=0, mode=0, value=30, countdown=0, random_id=0, LFSR=LFSR_SEED, sec_cnt=0.

FSM:
- SELECT:
  - start_p → COUNTDOWN, with countdown=COUNT_SEC and sec_cnt=0.
  - abort_p is ignored.
- COUNTDOWN:
  - sec_cnt increments each cycle.
  - When sec_cnt==CYC_PER_SEC-1: sec_cnt←0 and countdown←countdown-1.
  - If countdown==1 at that point: go to INGAME and set countdown←0.
  - abort_p → SELECT with countdown=0 and sec_cnt=0; abort has priority over second expiry.
  - start_p is ignored.
- INGAME:
  - finish==1 → FINISH on the next edge.
  - abort_p → SELECT; abort wins if it arrives in the same cycle as finish.
- FINISH:
  - start_p → SELECT.
  - abort_p → SELECT.
  - finish is ignored.
- finish is ignored in every state other than INGAME.
- Latency: state changes on the first clock edge after the qualifying pulse.

Selection (state==SELECT only; pulses are ignored in all other states, and mode/value hold during a game):
- mode_p:
  - Toggles mode and reloads value: 30 for the new timed mode, 10 for the new word mode.
  - Has priority over up_p/down_p in the same cycle.
- Timed mode: step 15, range 15..120.
- Word mode: step 5, range 5..50.
- up_p adds one step and saturates at the maximum.
- down_p subtracts one step and saturates at the minimum.
- up_p and down_p in the same cycle: value unchanged.
- start_p in the same cycle as up_p/down_p/mode_p: the state transition occurs and the selection pulses are ignored.

LFSR:
- 10-bit Fibonacci, taps x^10+x^7+1, advances every cycle in all states. Never zero; period 1023.
- random_id ← LFSR mod WORD_CNT, registered, so it is one cycle behind the LFSR.
- The mod reduction is done by conditional subtraction; no divider.

Test Plan:
- Apply rst for 2 cycles → state=0, mode=0, value=30, countdown=0, random_id=0; the second rst cycle mid-COUNTDOWN also returns to these values.
- In SELECT, with CYC_PER_SEC=4 for sim, pulse up_p 7 times → value 45,60,75,90,105,120,120. Then down_p 8 times → value ends at 15. Then mode_p → mode=1, value=10. Then up_p and down_p together → value stays 10.
- start_p with COUNT_SEC=3 and CYC_PER_SEC=4 → state=1 and countdown=3. countdown becomes 2, 1 at 4-cycle intervals. state=2 and countdown=0 exactly 12 cycles after entry.
- In INGAME, raise finish=1 → state=3 on the next edge. Then start_p → state=0. Raising finish while in SELECT → state stays 0.
- Pulse abort_p in the same cycle as finish during INGAME → state=0. Pulse abort_p in COUNTDOWN at the second boundary → state=0, countdown=0.
- Run 1023 cycles from reset → the LFSR returns to 10'h2A5, never reaches 0, and every random_id is < WORD_CNT.

Source files
------------

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl_if
//  Description : Handshake bundle between the game sequencer and its
//                surroundings. The master side (button/key front-end plus the
//                scoring datapath) drives the one-cycle strobes and the finish
//                flag; the slave side (game_ctrl) returns the game state,
//                selected mode/target, countdown and dictionary word id.
//  Signals     : start_p, abort_p, mode_p, up_p, down_p  one-cycle strobes
//                finish                                  game-over flag
//                state[1:0]      0=SELECT 1=COUNTDOWN 2=INGAME 3=FINISH
//                mode            0=timed, 1=word count
//                value[6:0]      selected target
//                countdown[1:0]  remaining countdown seconds
//                random_id[9:0]  dictionary word id
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_ctrl_if;
    logic       start_p;
    logic       abort_p;
    logic       mode_p;
    logic       up_p;
    logic       down_p;
    logic       finish;
    logic [1:0] state;
    logic       mode;
    logic [6:0] value;
    logic [1:0] countdown;
    logic [9:0] random_id;

    modport master (
        output start_p, abort_p, mode_p, up_p, down_p, finish,
        input  state, mode, value, countdown, random_id
    );

    modport slave (
        input  start_p, abort_p, mode_p, up_p, down_p, finish,
        output state, mode, value, countdown, random_id
    );
endinterface
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl
//  Description : Top-level sequencer of the typing game. Owns the
//                SELECT/COUNTDOWN/INGAME/FINISH state register, handles
//                mode/target selection from one-cycle strobes, runs the
//                pre-game countdown and free-runs a 10-bit LFSR that supplies
//                dictionary word ids reduced modulo WORD_CNT.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - game_ctrl_if.slave (strobes/finish in; state, mode,
//                       value, countdown, random_id out; all registered)
//  Parameters  : CYC_PER_SEC - clock cycles per countdown second
//                COUNT_SEC   - countdown start value (1..3)
//                WORD_CNT    - dictionary size, random_id in 0..WORD_CNT-1
//                LFSR_SEED   - nonzero LFSR reset value
//  Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int         CYC_PER_SEC = 100_000_000,
    parameter int         COUNT_SEC   = 3,
    parameter int         WORD_CNT    = 100,
    parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
    input  wire logic  clk,
    input  wire logic  rst,
    game_ctrl_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_select    = 2'd0;
    localparam logic [1:0] c_st_countdown = 2'd1;
    localparam logic [1:0] c_st_ingame    = 2'd2;
    localparam logic [1:0] c_st_finish    = 2'd3;

    localparam int                 c_sec_w    = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;
    localparam logic [c_sec_w-1:0] c_sec_last = c_sec_w'(CYC_PER_SEC - 1);
    localparam logic [1:0]         c_count_init = 2'(COUNT_SEC);

    // Timed mode: seconds, word mode: words
    localparam logic [6:0] c_t_step = 7'd15;
    localparam logic [6:0] c_t_min  = 7'd15;
    localparam logic [6:0] c_t_max  = 7'd120;
    localparam logic [6:0] c_t_init = 7'd30;
    localparam logic [6:0] c_w_step = 7'd5;
    localparam logic [6:0] c_w_min  = 7'd5;
    localparam logic [6:0] c_w_max  = 7'd50;
    localparam logic [6:0] c_w_init = 7'd10;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_mode;
    logic [6:0]         r_value;
    logic [1:0]         r_countdown;
    logic [c_sec_w-1:0] r_sec_cnt;
    logic [9:0]         r_lfsr;
    logic [9:0]         r_random_id;

    // ------------------------------------------------------------------
    // Selection arithmetic (saturating step up/down for the current mode)
    // ------------------------------------------------------------------
    logic [6:0] w_step;
    logic [6:0] w_min;
    logic [6:0] w_max;
    logic [7:0] w_sum;
    logic [6:0] w_value_up;
    logic [6:0] w_value_dn;

    always_comb begin
        w_step     = r_mode ? c_w_step : c_t_step;
        w_min      = r_mode ? c_w_min  : c_t_min;
        w_max      = r_mode ? c_w_max  : c_t_max;
        w_sum      = {1'b0, r_value} + {1'b0, w_step};
        w_value_up = (w_sum > {1'b0, w_max}) ? w_max : w_sum[6:0];
        // min+step is at most 30, so this compare cannot overflow
        w_value_dn = ({1'b0, r_value} < ({1'b0, w_min} + {1'b0, w_step})) ?
                     w_min : (r_value - w_step);
    end

    // ------------------------------------------------------------------
    // LFSR x^10 + x^7 + 1 (Fibonacci, shifting toward the MSB)
    // ------------------------------------------------------------------
    logic [9:0] w_lfsr_nxt;
    assign w_lfsr_nxt = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};

    // ------------------------------------------------------------------
    // LFSR mod WORD_CNT by restoring conditional subtraction: stage k
    // removes WORD_CNT*2^(9-k) if it fits. The LFSR is below
    // 1024 <= WORD_CNT*2^10, so ten stages leave the exact remainder, and
    // the remainder never grows so it always fits in 10 bits.
    // ------------------------------------------------------------------
    logic [9:0] w_rem [0:10];
    assign w_rem[0] = r_lfsr;

    generate
        for (genvar k = 0; k < 10; k++) begin : g_mod_stage
            localparam logic [19:0] c_div = 20'(WORD_CNT) << (9 - k);
            assign w_rem[k+1] = ({10'b0, w_rem[k]} >= c_div) ?
                                10'({10'b0, w_rem[k]} - c_div) : w_rem[k];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Game state machine, selection and word-id registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_select;
            r_mode      <= 1'b0;
            r_value     <= c_t_init;
            r_countdown <= 2'd0;
            r_sec_cnt   <= '0;
            r_lfsr      <= LFSR_SEED;
            r_random_id <= 10'd0;
        end else begin
            r_lfsr      <= w_lfsr_nxt;
            r_random_id <= w_rem[10];

            case (r_state)
                c_st_select: begin
                    // A start in the same cycle as selection strobes wins;
                    // selection is frozen once the game leaves SELECT.
                    if (bus.start_p) begin
                        r_state     <= c_st_countdown;
                        r_countdown <= c_count_init;
                        r_sec_cnt   <= '0;
                    end else if (bus.mode_p) begin
                        r_mode  <= ~r_mode;
                        r_value <= r_mode ? c_t_init : c_w_init;
                    end else if (bus.up_p && !bus.down_p) begin
                        r_value <= w_value_up;
                    end else if (bus.down_p && !bus.up_p) begin
                        r_value <= w_value_dn;
                    end
                end

                c_st_countdown: begin
                    if (bus.abort_p) begin
                        r_state     <= c_st_select;
                        r_countdown <= 2'd0;
                        r_sec_cnt   <= '0;
                    end else if (r_sec_cnt == c_sec_last) begin
                        r_sec_cnt <= '0;
                        if (r_countdown <= 2'd1) begin
                            r_state     <= c_st_ingame;
                            r_countdown <= 2'd0;
                        end else begin
                            r_countdown <= r_countdown - 2'd1;
                        end
                    end else begin
                        r_sec_cnt <= r_sec_cnt + 1'b1;
                    end
                end

                c_st_ingame: begin
                    if (bus.abort_p) begin
                        r_state <= c_st_select;
                    end else if (bus.finish) begin
                        r_state <= c_st_finish;
                    end
                end

                c_st_finish: begin
                    if (bus.start_p || bus.abort_p) begin
                        r_state <= c_st_select;
                    end
                end

                default: begin
                    r_state <= c_st_select;
                end
            endcase
        end
    end

    assign bus.state     = r_state;
    assign bus.mode      = r_mode;
    assign bus.value     = r_value;
    assign bus.countdown = r_countdown;
    assign bus.random_id = r_random_id;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_ctrl
//  Description : Self-checking bench for game_ctrl. Expected outputs are
//                pushed to a scoreboard queue as each directed step is driven
//                and popped for comparison one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    localparam int         c_cyc_per_sec = 4;
    localparam int         c_count_sec   = 3;
    localparam int         c_word_cnt    = 100;
    localparam logic [9:0] c_seed        = 10'h2A5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    game_ctrl_if bus ();

    game_ctrl #(
        .CYC_PER_SEC (c_cyc_per_sec),
        .COUNT_SEC   (c_count_sec),
        .WORD_CNT    (c_word_cnt),
        .LFSR_SEED   (c_seed)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        sb_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d required an entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        bus.start_p = 1'b0;
        bus.abort_p = 1'b0;
        bus.mode_p  = 1'b0;
        bus.up_p    = 1'b0;
        bus.down_p  = 1'b0;
    endtask

    task automatic expect_all(input string tag, input int st, input int md,
                              input int val, input int cd);
        push({tag, ".state"},     32'(st));
        push({tag, ".mode"},      32'(md));
        push({tag, ".value"},     32'(val));
        push({tag, ".countdown"}, 32'(cd));
    endtask

    task automatic check_all();
        pop_chk(32'(bus.state));
        pop_chk(32'(bus.mode));
        pop_chk(32'(bus.value));
        pop_chk(32'(bus.countdown));
    endtask

    // Drive whatever strobes are currently set for one edge, then compare.
    task automatic step(input string tag, input int st, input int md,
                        input int val, input int cd);
        expect_all(tag, st, md, val, cd);
        tick();
        clear_pulses();
        check_all();
    endtask

    // Twelve cycles of countdown after entry: 3,3,3,2,... then INGAME at 12.
    task automatic run_countdown(input string tag, input int md, input int val);
        int cd;
        for (int c = 1; c <= 12; c++) begin
            cd = (c < 4) ? 3 : (c < 8) ? 2 : (c < 12) ? 1 : 0;
            step(tag, (c < 12) ? 1 : 2, md, val, cd);
        end
    endtask

    task automatic check_reset(input string tag);
        expect_all(tag, 0, 0, 30, 0);
        check_all();
        push({tag, ".random_id"}, 32'd0);
        pop_chk(32'(bus.random_id));
    endtask

    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          up_exp [7];
        int          dn_exp [8];
        logic [9:0]  m;

        up_exp = '{45, 60, 75, 90, 105, 120, 120};
        dn_exp = '{105, 90, 75, 60, 45, 30, 15, 15};

        // ---------------- reset ----------------
        rst        = 1'b1;
        bus.finish = 1'b0;
        clear_pulses();
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;

        // ---------------- LFSR / random_id over a full period ----------------
        m = c_seed;
        for (int i = 0; i < 1023; i++) begin
            push("lfsr_rid", 32'(m % c_word_cnt));
            m = lfsr_next(m);
            tick();
            pop_chk(32'(bus.random_id));
            n_tests++;
            assert (bus.random_id < 10'(c_word_cnt)) else begin
                n_fail++;
                $error("FAIL rid_range: observed %0d expected below %0d",
                       bus.random_id, c_word_cnt);
            end
        end
        // After 1023 advances the LFSR is back at the seed: 0x2A5 = 677 -> 77
        push("lfsr_period", 32'd77);
        tick();
        pop_chk(32'(bus.random_id));

        // ---------------- selection, timed mode ----------------
        for (int i = 0; i < 7; i++) begin
            bus.up_p = 1'b1;
            step("up_timed", 0, 0, up_exp[i], 0);
        end
        for (int i = 0; i < 8; i++) begin
            bus.down_p = 1'b1;
            step("down_timed", 0, 0, dn_exp[i], 0);
        end
        bus.mode_p = 1'b1;
        step("mode_to_word", 0, 1, 10, 0);
        bus.up_p   = 1'b1;
        bus.down_p = 1'b1;
        step("up_and_down", 0, 1, 10, 0);

        // ---------------- selection, word mode ----------------
        for (int i = 0; i < 3; i++) begin
            bus.down_p = 1'b1;
            step("down_word", 0, 1, (i == 0) ? 5 : 5, 0);
        end
        for (int i = 0; i < 10; i++) begin
            bus.up_p = 1'b1;
            step("up_word", 0, 1, (10 + 5 * i > 50) ? 50 : 10 + 5 * i, 0);
        end
        bus.mode_p = 1'b1;
        bus.up_p   = 1'b1;
        step("mode_over_up", 0, 0, 30, 0);
        bus.abort_p = 1'b1;
        step("abort_in_select", 0, 0, 30, 0);

        // ---------------- countdown and game ----------------
        bus.start_p = 1'b1;
        bus.up_p    = 1'b1;
        step("start_with_up", 1, 0, 30, 3);
        run_countdown("countdown", 0, 30);
        bus.mode_p = 1'b1;
        bus.up_p   = 1'b1;
        step("ingame_sel_ignored", 2, 0, 30, 0);
        bus.finish = 1'b1;
        step("finish", 3, 0, 30, 0);
        step("finish_held", 3, 0, 30, 0);
        bus.finish  = 1'b0;
        bus.start_p = 1'b1;
        step("leave_result", 0, 0, 30, 0);
        bus.finish = 1'b1;
        step("finish_in_select", 0, 0, 30, 0);
        bus.finish = 1'b0;

        // abort together with finish in INGAME
        bus.start_p = 1'b1;
        step("start2", 1, 0, 30, 3);
        run_countdown("countdown2", 0, 30);
        bus.finish  = 1'b1;
        bus.abort_p = 1'b1;
        step("abort_with_finish", 0, 0, 30, 0);
        bus.finish = 1'b0;

        // abort from FINISH
        bus.start_p = 1'b1;
        step("start3", 1, 0, 30, 3);
        run_countdown("countdown3", 0, 30);
        bus.finish = 1'b1;
        step("finish3", 3, 0, 30, 0);
        bus.finish  = 1'b0;
        bus.abort_p = 1'b1;
        step("abort_from_finish", 0, 0, 30, 0);

        // abort exactly on a second boundary in COUNTDOWN
        bus.start_p = 1'b1;
        step("start4", 1, 0, 30, 3);
        step("cd4_1", 1, 0, 30, 3);
        step("cd4_2", 1, 0, 30, 3);
        bus.start_p = 1'b1;
        step("cd4_start_ignored", 1, 0, 30, 3);
        bus.abort_p = 1'b1;
        step("abort_at_boundary", 0, 0, 30, 0);
        step("after_abort", 0, 0, 30, 0);

        // ---------------- reset in the middle of COUNTDOWN ----------------
        bus.mode_p = 1'b1;
        step("mode_before_rst", 0, 1, 10, 0);
        bus.start_p = 1'b1;
        step("start5", 1, 1, 10, 3);
        step("cd5_1", 1, 1, 10, 3);
        rst = 1'b1;
        tick();
        tick();
        check_reset("reset_mid_countdown");
        rst = 1'b0;
        step("post_reset", 0, 0, 30, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
